// File: rtl/irq_seq_pkg.sv
// rtl/irq_seq_pkg.sv - shared constants, state types and priority helper for the IRQ service sequencer
package irq_seq_pkg;

    localparam int APB_AW  = 32;
    localparam int APB_DW  = 32;
    localparam int NUM_IRQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 16;
    localparam int HOLDOFF = 2;

    localparam logic [APB_AW-1:0] PEND_ADDR = 32'd1;
    localparam logic [APB_AW-1:0] CLR_ADDR  = 32'd8;
    localparam logic [APB_AW-1:0] CFG_ADDR  = 32'd9;
    localparam logic [APB_DW-1:0] CFG_VALUE = 32'd2;

    typedef enum logic [3:0] {
        ST_BOOT_SETUP,
        ST_BOOT_ACCESS,
        ST_WAIT_IRQ,
        ST_RD_SETUP,
        ST_RD_ACCESS,
        ST_DISPATCH,
        ST_CLR_SETUP,
        ST_CLR_ACCESS,
        ST_HOLDOFF
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_ACCESS
    } phase_t;

    // Index 0 is the highest priority, so the lowest set bit wins.
    function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_IRQ-1:0] bitmap);
        lowest_set = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (bitmap[i]) lowest_set = i[ID_W-1:0];
        end
    endfunction

endpackage

// File: rtl/irq_seq_apb_engine.sv
// rtl/irq_seq_apb_engine.sv - single-transfer APB master with access timeout and error detection
module irq_seq_apb_engine
    import irq_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [APB_AW-1:0] addr,
    input  logic [APB_DW-1:0] wdata,
    output logic              done,
    output logic [APB_DW-1:0] rdata,
    output logic              err_evt,
    output logic              err,
    output logic [APB_AW-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [APB_DW-1:0] pwdata,
    input  logic [APB_DW-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam logic [4:0] TO_LAST = 5'(TIMEOUT - 1);

    phase_t     phase;
    logic [4:0] tcnt;
    logic       in_access;
    logic       timeout;

    assign in_access = (phase == PH_ACCESS);
    assign timeout   = in_access && !pready && (tcnt == TO_LAST);
    assign done      = in_access && pready && !pslverr;
    assign err_evt   = (in_access && pready && pslverr) || timeout;
    assign psel      = (phase != PH_IDLE);
    assign penable   = in_access;
    assign rdata     = prdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= PH_IDLE;
            tcnt   <= '0;
            paddr  <= '0;
            pwdata <= '0;
            pwrite <= 1'b0;
            err    <= 1'b0;
        end else begin
            err <= err_evt;
            case (phase)
                PH_IDLE: begin
                    if (req) begin
                        phase  <= PH_SETUP;
                        paddr  <= addr;
                        pwdata <= wdata;
                        pwrite <= we;
                    end
                end
                PH_SETUP: begin
                    phase <= PH_ACCESS;
                    tcnt  <= '0;
                end
                PH_ACCESS: begin
                    if (pready || timeout) phase <= PH_IDLE;
                    else                   tcnt  <= tcnt + 5'd1;
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/irq_service_sequencer.sv
// rtl/irq_service_sequencer.sv - boots the interrupt controller, then reads, dispatches and clears interrupts
module irq_service_sequencer
    import irq_seq_pkg::*;
(
    input  logic              pclk_i,
    input  logic              rst_n_i,
    output logic [APB_AW-1:0] paddr_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [APB_DW-1:0] pwdata_o,
    input  logic [APB_DW-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i,
    input  logic              irq_i,
    output logic              svc_valid_o,
    output logic [ID_W-1:0]   svc_id_o,
    input  logic              svc_ready_i,
    output logic              busy_o,
    output logic              err_o,
    output logic [7:0]        spurious_cnt_o
);

    localparam logic [1:0] HOLD_LAST = 2'(HOLDOFF - 1);

    state_t             state, state_next;
    logic               req, we, done, err_evt;
    logic [APB_AW-1:0]  addr;
    logic [APB_DW-1:0]  wdata, rdata;
    logic [NUM_IRQ-1:0] bitmap;
    logic [1:0]         hcnt;

    assign bitmap      = rdata[NUM_IRQ-1:0];
    assign svc_valid_o = (state == ST_DISPATCH);
    assign busy_o      = (state != ST_WAIT_IRQ);

    irq_seq_apb_engine u_apb (
        .clk     (pclk_i),
        .rst_n   (rst_n_i),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .done    (done),
        .rdata   (rdata),
        .err_evt (err_evt),
        .err     (err_o),
        .paddr   (paddr_o),
        .psel    (psel_o),
        .penable (penable_o),
        .pwrite  (pwrite_o),
        .pwdata  (pwdata_o),
        .prdata  (prdata_i),
        .pready  (pready_i),
        .pslverr (pslverr_i)
    );

    // *_SETUP states issue the request; the engine drives the APB SETUP phase on the following cycle.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        we         = 1'b0;
        addr       = '0;
        wdata      = '0;
        case (state)
            ST_BOOT_SETUP: begin
                req        = 1'b1;
                we         = 1'b1;
                addr       = CFG_ADDR;
                wdata      = CFG_VALUE;
                state_next = ST_BOOT_ACCESS;
            end
            ST_BOOT_ACCESS: begin
                if (done)         state_next = ST_WAIT_IRQ;
                else if (err_evt) state_next = ST_BOOT_SETUP;
            end
            ST_WAIT_IRQ: begin
                if (irq_i) state_next = ST_RD_SETUP;
            end
            ST_RD_SETUP: begin
                req        = 1'b1;
                addr       = PEND_ADDR;
                state_next = ST_RD_ACCESS;
            end
            ST_RD_ACCESS: begin
                if (done)         state_next = (bitmap == '0) ? ST_HOLDOFF : ST_DISPATCH;
                else if (err_evt) state_next = ST_HOLDOFF;
            end
            ST_DISPATCH: begin
                if (svc_ready_i) state_next = ST_CLR_SETUP;
            end
            ST_CLR_SETUP: begin
                req        = 1'b1;
                we         = 1'b1;
                addr       = CLR_ADDR;
                wdata      = 32'd1 << svc_id_o;
                state_next = ST_CLR_ACCESS;
            end
            ST_CLR_ACCESS: begin
                if (done || err_evt) state_next = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (hcnt == HOLD_LAST) state_next = ST_WAIT_IRQ;
            end
            default: state_next = ST_BOOT_SETUP;
        endcase
    end

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= ST_BOOT_SETUP;
            svc_id_o       <= '0;
            spurious_cnt_o <= '0;
            hcnt           <= '0;
        end else begin
            state <= state_next;
            hcnt  <= (state == ST_HOLDOFF) ? hcnt + 2'd1 : 2'd0;
            if (state == ST_RD_ACCESS && done) begin
                if (bitmap != '0)                 svc_id_o       <= lowest_set(bitmap);
                else if (spurious_cnt_o != 8'hFF) spurious_cnt_o <= spurious_cnt_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_irq_service_sequencer.sv
// tb/tb_irq_service_sequencer.sv - directed self-checking bench for irq_service_sequencer
module tb_irq_service_sequencer;

    logic        pclk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [31:0] paddr_o;
    logic        psel_o, penable_o, pwrite_o;
    logic [31:0] pwdata_o;
    logic [31:0] prdata_i = '0;
    logic        pready_i = 1'b1;
    logic        pslverr_i = 1'b0;
    logic        irq_i = 1'b0;
    logic        svc_valid_o;
    logic [1:0]  svc_id_o;
    logic        svc_ready_i = 1'b0;
    logic        busy_o, err_o;
    logic [7:0]  spurious_cnt_o;

    int checks = 0;
    int failures = 0;

    irq_service_sequencer dut (
        .pclk_i         (pclk_i),
        .rst_n_i        (rst_n_i),
        .paddr_o        (paddr_o),
        .psel_o         (psel_o),
        .penable_o      (penable_o),
        .pwrite_o       (pwrite_o),
        .pwdata_o       (pwdata_o),
        .prdata_i       (prdata_i),
        .pready_i       (pready_i),
        .pslverr_i      (pslverr_i),
        .irq_i          (irq_i),
        .svc_valid_o    (svc_valid_o),
        .svc_id_o       (svc_id_o),
        .svc_ready_i    (svc_ready_i),
        .busy_o         (busy_o),
        .err_o          (err_o),
        .spurious_cnt_o (spurious_cnt_o)
    );

    always #5 pclk_i = ~pclk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk_i);
        #1;
    endtask

    task automatic wait_setup(input string tag, input logic [31:0] exp_addr,
                              input logic exp_we, input logic [31:0] exp_wdata);
        logic found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (psel_o && !penable_o) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_found"}, found, 1);
        chk({tag, "_addr"}, paddr_o, exp_addr);
        chk({tag, "_we"}, pwrite_o, exp_we);
        if (exp_we) chk({tag, "_wdata"}, pwdata_o, exp_wdata);
    endtask

    task automatic wait_idle(input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy_o) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_idle"}, found, 1);
    endtask

    // Waits for the dispatch, holds off ready for one cycle, completes it, then checks the clear write.
    task automatic service(input string tag, input logic [1:0] exp_id);
        logic found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (svc_valid_o) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_valid"}, found, 1);
        chk({tag, "_id"}, svc_id_o, exp_id);
        tick();
        chk({tag, "_hold"}, {svc_valid_o, svc_id_o}, {1'b1, exp_id});
        svc_ready_i = 1'b1;
        tick();
        svc_ready_i = 1'b0;
        chk({tag, "_drop"}, svc_valid_o, 0);
        wait_setup({tag, "_clr"}, 32'd8, 1'b1, 32'd1 << exp_id);
    endtask

    initial begin
        logic seen_valid, seen_err, found;
        int   n;

        // Reset state and boot write with an always-ready slave
        tick();
        tick();
        chk("rst_apb", {psel_o, penable_o, pwrite_o}, 0);
        chk("rst_paddr", paddr_o, 0);
        chk("rst_pwdata", pwdata_o, 0);
        chk("rst_svc", {svc_valid_o, svc_id_o, err_o}, 0);
        chk("rst_spur", spurious_cnt_o, 0);
        chk("rst_busy", busy_o, 1);
        rst_n_i = 1'b1;
        tick();
        chk("boot_setup", {psel_o, penable_o}, 2'b10);
        chk("boot_addr", paddr_o, 9);
        chk("boot_data", {pwrite_o, pwdata_o}, {1'b1, 32'd2});
        tick();
        chk("boot_access", {psel_o, penable_o}, 2'b11);
        tick();
        chk("boot_done", {psel_o, penable_o, busy_o}, 0);

        // Two pending sources serviced in priority order
        irq_i = 1'b1;
        prdata_i = 32'hC;
        wait_setup("rd_c", 32'd1, 1'b0, 32'd0);
        service("svc2", 2'd2);
        prdata_i = 32'h8;
        service("svc3", 2'd3);
        irq_i = 1'b0;
        prdata_i = 32'h0;
        wait_idle("loop_end");

        // Boot write timing out once, then succeeding
        rst_n_i = 1'b0;
        pready_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        wait_setup("to_boot", 32'd9, 1'b1, 32'd2);
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (err_o) begin
                found = 1'b1;
                break;
            end
        end
        chk("to_err_seen", found, 1);
        chk("to_cycles", n, 17);
        chk("to_psel_drop", {psel_o, penable_o}, 0);
        tick();
        chk("to_err_pulse", err_o, 0);
        chk("to_retry", {psel_o, penable_o, paddr_o}, {2'b10, 32'd9});
        pready_i = 1'b1;
        wait_idle("to_done");

        // Spurious interrupts: counted, never dispatched, saturating
        irq_i = 1'b1;
        prdata_i = 32'h0;
        seen_valid = 1'b0;
        seen_err = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (spurious_cnt_o != 0) break;
        end
        chk("spur_first", spurious_cnt_o, 1);
        for (int i = 0; i < 2000; i++) begin
            tick();
            seen_valid |= svc_valid_o;
            seen_err |= err_o;
        end
        chk("spur_sat", spurious_cnt_o, 255);
        chk("spur_no_svc", {seen_valid, seen_err}, 0);
        irq_i = 1'b0;
        wait_idle("spur_end");

        // Slave error on the clear write leads to a re-read and the same ID again
        irq_i = 1'b1;
        prdata_i = 32'h2;
        service("pse1", 2'd1);
        pslverr_i = 1'b1;
        tick();
        tick();
        chk("pse_err", err_o, 1);
        pslverr_i = 1'b0;
        tick();
        chk("pse_err_pulse", err_o, 0);
        service("pse2", 2'd1);
        irq_i = 1'b0;
        prdata_i = 32'h0;
        wait_idle("pse_end");

        // Reset in the middle of a stalled read
        irq_i = 1'b1;
        prdata_i = 32'h1;
        pready_i = 1'b0;
        wait_setup("mid_rd", 32'd1, 1'b0, 32'd0);
        tick();
        chk("mid_access", {psel_o, penable_o}, 2'b11);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("mid_rst_apb", {psel_o, penable_o, pwrite_o}, 0);
        chk("mid_rst_bus", {paddr_o, pwdata_o}, 64'd0);
        chk("mid_rst_svc", {svc_valid_o, svc_id_o, err_o, spurious_cnt_o}, 0);
        irq_i = 1'b0;
        prdata_i = 32'h0;
        pready_i = 1'b1;
        tick();
        rst_n_i = 1'b1;
        wait_setup("reboot", 32'd9, 1'b1, 32'd2);
        wait_idle("reboot_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
